// File: rtl/pipelined_mag_comparator.sv
// Pipelined WIDTH-bit magnitude comparator that resolves one CHUNK-bit slice per stage, MSB slice first.
// It also keeps saturating GT/EQ/LT event counters.
module pipelined_mag_comparator #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cnt_clr,
  output logic             out_valid,
  output logic             greater,
  output logic             equal,
  output logic             lesser,
  output logic [CNT_W-1:0] gt_count,
  output logic [CNT_W-1:0] eq_count,
  output logic [CNT_W-1:0] lt_count
);

  localparam int NSTG = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int PW   = NSTG * CHUNK;
  localparam int NOPS = (NSTG > 1) ? NSTG - 1 : 1;

  logic [PW-1:0]    a_cap, b_cap;
  logic [NSTG-1:0]  vld_q, vld_d, gt_q, gt_d, lt_q, lt_d;
  logic [PW-1:0]    a_q [NOPS];
  logic [PW-1:0]    a_d [NOPS];
  logic [PW-1:0]    b_q [NOPS];
  logic [PW-1:0]    b_d [NOPS];
  logic             equal_q, equal_d;
  logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d, eq_cnt_q, eq_cnt_d, lt_cnt_q, lt_cnt_d;

  logic [PW-1:0]    cur_a, cur_b;
  logic [CHUNK-1:0] sl_a, sl_b;
  logic             in_v, in_g, in_l;
  int               prv, wix;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  always_comb begin
    a_cap = '0;
    b_cap = '0;
    a_cap[WIDTH-1:0] = a;
    b_cap[WIDTH-1:0] = b;
    a_cap[WIDTH-1]   = a[WIDTH-1] ^ signed_mode;
    b_cap[WIDTH-1]   = b[WIDTH-1] ^ signed_mode;
  end

  always_comb begin
    vld_d = '0;
    gt_d  = gt_q;
    lt_d  = lt_q;
    a_d   = a_q;
    b_d   = b_q;
    cur_a = '0;
    cur_b = '0;
    sl_a  = '0;
    sl_b  = '0;
    in_v  = 1'b0;
    in_g  = 1'b0;
    in_l  = 1'b0;
    prv   = 0;
    wix   = 0;
    for (int k = 0; k < NSTG; k++) begin
      prv = (k == 0) ? 0 : k - 1;
      wix = (k < NOPS) ? k : NOPS - 1;
      if (k == 0) begin
        cur_a = a_cap;
        cur_b = b_cap;
        in_v  = in_valid;
        in_g  = 1'b0;
        in_l  = 1'b0;
      end else begin
        cur_a = a_q[prv];
        cur_b = b_q[prv];
        in_v  = vld_q[prv];
        in_g  = gt_q[prv];
        in_l  = lt_q[prv];
      end
      sl_a     = cur_a[PW-1-k*CHUNK -: CHUNK];
      sl_b     = cur_b[PW-1-k*CHUNK -: CHUNK];
      vld_d[k] = in_v;
      // Stage data only moves with a valid transaction, so the last stage holds its result.
      if (in_v) begin
        gt_d[k] = in_g;
        lt_d[k] = in_l;
        if (!(in_g || in_l) && (sl_a != sl_b)) begin
          gt_d[k] = (sl_a > sl_b);
          lt_d[k] = (sl_a < sl_b);
        end
        if (k < NSTG - 1) begin
          a_d[wix] = cur_a;
          b_d[wix] = cur_b;
        end
      end
    end
    equal_d = equal_q;
    if (vld_d[NSTG-1]) begin
      equal_d = ~(gt_d[NSTG-1] | lt_d[NSTG-1]);
    end
  end

  // Counters see the registered result, so a clear in the same cycle drops that result.
  always_comb begin
    gt_cnt_d = gt_cnt_q;
    eq_cnt_d = eq_cnt_q;
    lt_cnt_d = lt_cnt_q;
    if (cnt_clr) begin
      gt_cnt_d = '0;
      eq_cnt_d = '0;
      lt_cnt_d = '0;
    end else if (vld_q[NSTG-1]) begin
      if (gt_q[NSTG-1]) begin
        if (gt_cnt_q != '1) gt_cnt_d = gt_cnt_q + CNT_W'(1);
      end else if (lt_q[NSTG-1]) begin
        if (lt_cnt_q != '1) lt_cnt_d = lt_cnt_q + CNT_W'(1);
      end else begin
        if (eq_cnt_q != '1) eq_cnt_d = eq_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      gt_q     <= '0;
      lt_q     <= '0;
      equal_q  <= 1'b0;
      gt_cnt_q <= '0;
      eq_cnt_q <= '0;
      lt_cnt_q <= '0;
      for (int i = 0; i < NOPS; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      vld_q    <= vld_d;
      gt_q     <= gt_d;
      lt_q     <= lt_d;
      equal_q  <= equal_d;
      gt_cnt_q <= gt_cnt_d;
      eq_cnt_q <= eq_cnt_d;
      lt_cnt_q <= lt_cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

  assign out_valid = vld_q[NSTG-1];
  assign greater   = gt_q[NSTG-1];
  assign lesser    = lt_q[NSTG-1];
  assign equal     = equal_q;
  assign gt_count  = gt_cnt_q;
  assign eq_count  = eq_cnt_q;
  assign lt_count  = lt_cnt_q;

endmodule

// File: tb/tb_pipelined_mag_comparator.sv
// Testbench for pipelined_mag_comparator: directed and random stimulus checked against a queue-based reference model.
// A second instance with 2-bit counters exercises counter saturation.
module tb_pipelined_mag_comparator;

  localparam int NSTG = 4;
  localparam int MAXW = 65535;
  localparam int MAXS = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        signed_mode = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;

  logic        out_valid, greater, equal, lesser;
  logic [15:0] gt_count, eq_count, lt_count;
  logic        s_out_valid, s_greater, s_equal, s_lesser;
  logic [1:0]  s_gt_count, s_eq_count, s_lt_count;

  pipelined_mag_comparator #(.WIDTH(16), .CHUNK(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .signed_mode(signed_mode),
    .a(a), .b(b), .cnt_clr(cnt_clr), .out_valid(out_valid), .greater(greater),
    .equal(equal), .lesser(lesser), .gt_count(gt_count), .eq_count(eq_count),
    .lt_count(lt_count)
  );

  pipelined_mag_comparator #(.WIDTH(16), .CHUNK(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .signed_mode(signed_mode),
    .a(a), .b(b), .cnt_clr(cnt_clr), .out_valid(s_out_valid), .greater(s_greater),
    .equal(s_equal), .lesser(s_lesser), .gt_count(s_gt_count), .eq_count(s_eq_count),
    .lt_count(s_lt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int r;
  } ent_t;

  ent_t pend[$];
  bit   exp_v;
  int   exp_r;
  int   gtc, eqc, ltc, sgtc, seqc, sltc;
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // 0 = greater, 1 = equal, 2 = lesser
  function automatic int refCompare(input bit sm, input logic [15:0] x, input logic [15:0] y);
    longint xi, yi;
    xi = sm ? longint'($signed(x)) : longint'(x);
    yi = sm ? longint'($signed(y)) : longint'(y);
    if (xi > yi) return 0;
    if (xi == yi) return 1;
    return 2;
  endfunction

  function automatic int satInc(input int c, input int mx);
    return (c >= mx) ? mx : c + 1;
  endfunction

  task automatic modelReset();
    pend.delete();
    exp_v = 1'b0;
    exp_r = 3;
    gtc = 0; eqc = 0; ltc = 0;
    sgtc = 0; seqc = 0; sltc = 0;
  endtask

  task automatic modelEdge();
    ent_t e;
    if (cnt_clr) begin
      gtc = 0; eqc = 0; ltc = 0;
      sgtc = 0; seqc = 0; sltc = 0;
    end else if (exp_v) begin
      case (exp_r)
        0: begin gtc = satInc(gtc, MAXW); sgtc = satInc(sgtc, MAXS); end
        1: begin eqc = satInc(eqc, MAXW); seqc = satInc(seqc, MAXS); end
        default: begin ltc = satInc(ltc, MAXW); sltc = satInc(sltc, MAXS); end
      endcase
    end
    e.v = in_valid;
    e.r = in_valid ? refCompare(signed_mode, a, b) : 0;
    pend.push_back(e);
    exp_v = 1'b0;
    if (pend.size() == NSTG) begin
      e = pend.pop_front();
      exp_v = e.v;
      if (e.v) exp_r = e.r;
    end
  endtask

  task automatic checkAll();
    checkOutput("out_valid", 32'(out_valid), 32'(exp_v));
    checkOutput("greater", 32'(greater), 32'(exp_r == 0));
    checkOutput("equal", 32'(equal), 32'(exp_r == 1));
    checkOutput("lesser", 32'(lesser), 32'(exp_r == 2));
    checkOutput("gt_count", 32'(gt_count), 32'(gtc));
    checkOutput("eq_count", 32'(eq_count), 32'(eqc));
    checkOutput("lt_count", 32'(lt_count), 32'(ltc));
    checkOutput("sat_out_valid", 32'(s_out_valid), 32'(exp_v));
    checkOutput("sat_result", {29'd0, s_greater, s_equal, s_lesser},
                {29'd0, exp_r == 0, exp_r == 1, exp_r == 2});
    checkOutput("sat_gt_count", 32'(s_gt_count), 32'(sgtc));
    checkOutput("sat_eq_count", 32'(s_eq_count), 32'(seqc));
    checkOutput("sat_lt_count", 32'(s_lt_count), 32'(sltc));
  endtask

  task automatic applyStimulus(input bit v, input bit sm, input logic [15:0] x,
                               input logic [15:0] y, input bit clr);
    in_valid    = v;
    signed_mode = sm;
    a           = x;
    b           = y;
    cnt_clr     = clr;
    @(posedge clk);
    modelEdge();
    #1;
    checkAll();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_flags"}, {28'd0, out_valid, greater, equal, lesser}, 32'd0);
    checkOutput({tag, "_counts"}, {gt_count, eq_count | lt_count}, 32'd0);
    checkOutput({tag, "_sat"}, {26'd0, s_out_valid, s_greater, s_equal, s_lesser,
                                s_gt_count | s_eq_count | s_lt_count}, 32'd0);
  endtask

  initial begin
    logic [15:0] x, y;
    int          mode;
    modelReset();

    // Reset held with inputs toggling: nothing moves.
    for (int i = 0; i < 4; i++) begin
      in_valid    = 1'b1;
      signed_mode = 1'($urandom);
      a           = 16'($urandom);
      b           = 16'($urandom);
      cnt_clr     = 1'($urandom);
      @(posedge clk);
      #1;
      checkAllZero("in_reset");
    end
    in_valid = 1'b0;
    cnt_clr  = 1'b0;
    #2 rst_n = 1'b1;
    idle(3);

    // Unsigned and signed interpretation of the same operands.
    applyStimulus(1'b1, 1'b0, 16'h8000, 16'h7FFF, 1'b0);
    idle(5);
    applyStimulus(1'b1, 1'b1, 16'h8000, 16'h7FFF, 1'b0);
    idle(4);
    applyStimulus(1'b1, 1'b1, 16'hFFFF, 16'hFFFE, 1'b0);
    idle(4);

    // Low-slice decisions with a one-cycle gap in the stream.
    applyStimulus(1'b1, 1'b0, 16'h1235, 16'h1234, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h1234, 16'h1234, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h1234, 16'h1235, 1'b0);
    idle(5);

    // Saturation of the 2-bit counters, then a clear that swallows an LT result.
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
    idle(5);
    applyStimulus(1'b1, 1'b0, 16'h0001, 16'h0002, 1'b0);
    idle(3);
    checkOutput("lt_visible", 32'(lesser & out_valid), 32'd1);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    idle(2);
    checkOutput("lt_after_clr", 32'(lt_count), 32'd0);
    checkOutput("sat_gt_after_clr", 32'(s_gt_count), 32'd0);

    // Asynchronous reset with transactions in flight.
    applyStimulus(1'b1, 1'b0, 16'h00F0, 16'h000F, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h8000, 16'h0001, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkAllZero("async_rst");
    modelReset();
    in_valid = 1'b1;
    a        = 16'h0003;
    b        = 16'h0004;
    @(posedge clk);
    #1;
    checkAll();
    #2 rst_n = 1'b1;
    idle(6);

    // Random traffic with equal operands, single-bit differences and occasional clears.
    for (int i = 0; i < 400; i++) begin
      x    = 16'($urandom);
      mode = $urandom_range(0, 3);
      if (mode == 0)      y = x;
      else if (mode == 1) y = x ^ (16'h1 << $urandom_range(0, 15));
      else                y = 16'($urandom);
      applyStimulus(($urandom_range(0, 9) < 7), 1'($urandom), x, y, ($urandom_range(0, 39) == 0));
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
